// File: rtl/multiplier_if.sv
// -----------------------------------------------------------------------------
// multiplier_if
// Start/done handshake bundle between the control unit and the sequential
// 32x32 signed multiplier (same handshake as the divider).
//
// Signals:
//   a     [31:0] signed multiplicand, sampled on an accepted start
//   b     [31:0] signed multiplier, sampled on an accepted start
//   start        request a multiply (level-sampled each clock edge)
//   hi    [31:0] product bits [63:32], registered
//   lo    [31:0] product bits [31:0], registered
//   done         one-cycle pulse: hi/lo freshly valid
//   busy         high while an operation is in progress
//
// Modports:
//   master : control unit side (drives a/b/start, observes results)
//   slave  : multiplier side
// -----------------------------------------------------------------------------
interface multiplier_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic        busy;

  modport master (
    output a,
    output b,
    output start,
    input  hi,
    input  lo,
    input  done,
    input  busy
  );

  modport slave (
    input  a,
    input  b,
    input  start,
    output hi,
    output lo,
    output done,
    output busy
  );
endinterface

// File: rtl/multiplier.sv
// -----------------------------------------------------------------------------
// multiplier
// Sequential 32x32 signed multiplier for the ALU HI/LO path. Radix-2 Booth,
// one step per clock, 32 steps. The 64-bit two's-complement product is
// written to hi (upper word) and lo (lower word) on the edge that performs
// the final step, together with a one-cycle done pulse.
//
// Ports:
//   clk    : system clock, all state updates on the rising edge
//   reset  : synchronous, active-high
//   bus    : multiplier_if.slave (a, b, start in; hi, lo, done, busy out)
//
// Timing: start sampled while idle on edge E0; steps on E1..E32; done=1 and
// hi/lo valid after E32; busy=1 after E0 through E31. A start presented in
// the done cycle is accepted immediately (FSM is already idle).
// -----------------------------------------------------------------------------
module multiplier (
  input  logic        clk,
  input  logic        reset,
  multiplier_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Count value at which the current edge performs the 32nd (last) step.
  localparam logic [5:0] LAST_STEP = 6'd31;

  state_t      state;
  logic [32:0] m_reg;     // multiplicand, sign-extended to 33 bits
  logic [32:0] acc;       // Booth accumulator A
  logic [31:0] q_reg;     // multiplier / low product word Q
  logic        q_1;       // Booth history bit
  logic [5:0]  count;     // completed steps

  logic [65:0] step_vec;  // {A, Q, q_1} after one Booth step
  logic [32:0] acc_next;
  logic [31:0] q_next;
  logic        q_1_next;

  // Sign-extend a 32-bit operand to the 33-bit datapath width. The extra bit
  // keeps A +/- M from overflowing even for a = 0x80000000.
  function automatic logic [32:0] sign_extend33(input logic [31:0] value);
    return {value[31], value};
  endfunction

  // One radix-2 Booth step: conditional add/subtract of M selected by
  // {Q[0], q_1}, then arithmetic right shift of {A, Q, q_1} by one.
  function automatic logic [65:0] booth_step(
    input logic [32:0] acc_in,
    input logic [32:0] m_in,
    input logic [31:0] q_in,
    input logic        q_1_in
  );
    logic [32:0] sum;
    case ({q_in[0], q_1_in})
      2'b01:   sum = acc_in + m_in;
      2'b10:   sum = acc_in - m_in;
      default: sum = acc_in;
    endcase
    // Concatenating the sign bit in front and dropping the old q_1 is
    // exactly the one-bit arithmetic shift of the 66-bit {A, Q, q_1}.
    return {sum[32], sum, q_in};
  endfunction

  // Next-step datapath value, consumed only while running.
  always_comb begin
    step_vec = booth_step(acc, m_reg, q_reg, q_1);
    acc_next = step_vec[65:33];
    q_next   = step_vec[32:1];
    q_1_next = step_vec[0];
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      m_reg    <= 33'd0;
      acc      <= 33'd0;
      q_reg    <= 32'd0;
      q_1      <= 1'b0;
      count    <= 6'd0;
      bus.hi   <= 32'd0;
      bus.lo   <= 32'd0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // done is a single-cycle pulse; it always drops on the edge after.
          bus.done <= 1'b0;
          if (bus.start) begin
            m_reg    <= sign_extend33(bus.a);
            acc      <= 33'd0;
            q_reg    <= bus.b;
            q_1      <= 1'b0;
            count    <= 6'd0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end

        RUN: begin
          // start is deliberately ignored here; operands were latched on E0.
          acc      <= acc_next;
          q_reg    <= q_next;
          q_1      <= q_1_next;
          count    <= count + 6'd1;
          if (count == LAST_STEP) begin
            // Product is {A[31:0], Q} after the final shift; A[32] only
            // duplicates the sign at this point.
            bus.hi   <= acc_next[31:0];
            bus.lo   <= q_next;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            bus.done <= 1'b0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end

        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// -----------------------------------------------------------------------------
// tb_multiplier
// Self-checking bench for the sequential Booth multiplier. Expected products
// come from 64-bit signed arithmetic on the operands (or literal constants for
// the directed cases); timing is measured with a free-running cycle counter.
// -----------------------------------------------------------------------------
module tb_multiplier;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc_now;

  multiplier_if mif ();

  multiplier dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running edge counter for absolute timing checks.
  always @(posedge clk) cyc_now <= cyc_now + 1;

  // Hard time limit so the run can never hang.
  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: exact signed 64-bit product.
  function automatic logic [63:0] ref_product(input logic [31:0] x,
                                              input logic [31:0] y);
    longint px;
    longint py;
    px = longint'($signed(x));
    py = longint'($signed(y));
    return 64'(px * py);
  endfunction

  // Present start for one edge (called at a negedge; returns at the negedge
  // right after the accepting edge).
  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    mif.a     = x;
    mif.b     = y;
    mif.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mif.start = 1'b0;
  endtask

  // Wait for done, scrambling a/b every cycle and optionally pulsing start
  // so that it is sampled on edge number pulse_at after the start edge.
  task automatic wait_done(input int pulse_at, input logic [31:0] held_hi,
                           input logic [31:0] held_lo, output int cycles);
    int busy_bad;
    int hold_bad;
    busy_bad = 0;
    hold_bad = 0;
    cycles   = 0;
    while (mif.done !== 1'b1 && cycles < 40) begin
      if (mif.busy !== 1'b1) busy_bad++;
      if (mif.hi !== held_hi || mif.lo !== held_lo) hold_bad++;
      mif.a     = $urandom;
      mif.b     = $urandom;
      mif.start = (cycles == pulse_at - 1);
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    mif.start = 1'b0;
    check("busy_during_run", 64'(busy_bad), 64'd0);
    check("hold_during_run", 64'(hold_bad), 64'd0);
  endtask

  // Full operation: issue, wait, check latency, product and busy release.
  task automatic do_mult(input string tag, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] expected,
                         input int pulse_at);
    logic [31:0] h;
    logic [31:0] l;
    int          cycles;
    h = mif.hi;
    l = mif.lo;
    issue(x, y);
    wait_done(pulse_at, h, l, cycles);
    check({tag, "_latency"}, 64'(cycles), 64'd32);
    check({tag, "_product"}, {mif.hi, mif.lo}, expected);
    check({tag, "_busy_at_done"}, 64'(mif.busy), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [5];
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h0000_0001;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int          t_first;
    int          done_seen;
    logic [31:0] x;
    logic [31:0] y;

    checks    = 0;
    failures  = 0;
    cyc_now   = 0;
    reset     = 1'b1;
    mif.a     = 32'd0;
    mif.b     = 32'd0;
    mif.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state.
    check("reset_hi",   64'(mif.hi),   64'd0);
    check("reset_lo",   64'(mif.lo),   64'd0);
    check("reset_done", 64'(mif.done), 64'd0);
    check("reset_busy", 64'(mif.busy), 64'd0);

    // Directed products with literal expectations.
    do_mult("m7xm3", 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, -1);
    @(posedge clk);
    @(negedge clk);
    check("done_single_cycle", 64'(mif.done), 64'd0);
    do_mult("min_sq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1);
    do_mult("max_sq", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, -1);
    do_mult("min_x1", 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, -1);

    // start during RUN (sampled on the 10th edge) and wandering operands.
    do_mult("ignore_start", 32'd5, 32'd6, 64'd30, 10);
    @(posedge clk);
    @(negedge clk);
    check("ignore_start_idle_after", 64'(mif.busy), 64'd0);

    // Reset aborts an operation in flight.
    issue(32'd12, 32'd12);
    repeat (14) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(mif.busy), 64'd0);
    check("abort_hi",   64'(mif.hi),   64'd0);
    check("abort_lo",   64'(mif.lo),   64'd0);
    check("abort_done", 64'(mif.done), 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (mif.done === 1'b1) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    do_mult("after_abort", 32'd2, 32'd3, 64'd6, -1);

    // Back-to-back: second start presented in the done cycle.
    @(posedge clk);
    @(negedge clk);
    do_mult("b2b_first", 32'd3, 32'd4, 64'd12, -1);
    t_first = cyc_now;
    do_mult("b2b_second", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, -1);
    check("b2b_spacing", 64'(cyc_now - t_first), 64'd33);

    // Random signed pairs against the arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      x = pick_operand();
      y = pick_operand();
      do_mult("rand", x, y, ref_product(x, y), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
